hamming_enc_arbiter: RTL
========================

Name: hamming_enc_arbiter

Overview:
- Shares one hamming_encoder (Hamming(7,4)) between two nibble requesters.
- Requesters use valid/ready; grants are round-robin with a configurable burst limit.
- The codeword goes to a single registered output slot with valid/ready backpressure and a source tag.
- Sits between the two nibble producers and the downstream codeword sink/serializer.

Parameters:
- MAX_BURST, 1, max consecutive grants to one requester while the other is waiting (range 1..15).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a nibble
- req0_data  input  4  requester 0 nibble
- req0_ready  output  1  requester 0 nibble accepted this cycle (when valid)
- req1_valid  input  1  requester 1 has a nibble
- req1_data  input  4  requester 1 nibble
- req1_ready  output  1  requester 1 nibble accepted this cycle (when valid)
- out_valid  output  1  out_code/out_src hold a codeword
- out_code  output  7  codeword from hamming_encoder, registered
- out_src  output  1  requester that produced out_code
- out_ready  input  1  sink consumes the codeword when out_valid is high

Behaviour:
- Codeword map, bit 0 upward:
  - [0] = d0^d1^d3
  - [1] = d0^d2^d3
  - [2] = d0
  - [3] = d1^d2^d3
  - [4] = d1
  - [5] = d2
  - [6] = d3
- Arbiter state: owner (1b) and cnt (4b, saturating at MAX_BURST).
- Reset values: owner=0, cnt=0, out_valid=0, out_code=0, out_src=0. reqN_ready=0 while rst is high.
- slot_free = !out_valid || out_ready.
- Selection, combinational:
  - Only one valid: select it.
  - Both valid: select owner if cnt < MAX_BURST, else the other.
  - None valid: no selection.
- reqN_ready = slot_free && reqN_valid && (selected == N). The combinational valid-to-ready path is allowed. Never both ready at once.
- Transfer happens when reqN_valid && reqN_ready. On the next edge:
  - out_code = encode(reqN_data), out_src = N, out_valid = 1.
  - If N == owner: cnt = min(cnt+1, MAX_BURST).
  - Otherwise: owner = N, cnt = 1.
- Latency: exactly 1 cycle from transfer to out_valid.
- Full throughput: 1 codeword per cycle when out_ready is held high.
- Output handshake:
  - out_valid && out_ready with no new transfer: out_valid -> 0 next cycle.
  - Pop and transfer in the same cycle: out_valid stays 1 and new data loads.
- Stall: while out_valid && !out_ready, out_code/out_src/out_valid hold and both readys are 0.
- Idle cycles (no transfer) leave owner/cnt unchanged.
- MAX_BURST=1 gives strict alternation under contention, starting with requester 0 after reset.
- Reset mid-stall: the pending codeword is dropped and arbiter state returns to the reset values.

Optional Feature:
- Macro HAMMING_ARB_SECDED_EN.
- Defined:
  - Adds output port out_pall (1b), registered alongside out_code, equal to the XOR of all 7 out_code bits. This forms an extended (8,4) SECDED code.
  - Reset value 0; holds under stall like out_code.
- Undefined: port absent, all other behaviour identical.

Test Plan:
- Reset, then req0_valid=1 with data 4'hB, req1 idle, out_ready=1 -> req0_ready=1; next cycle out_valid=1, out_code=7'h55, out_src=0 (out_pall=0 if SECDED).
- MAX_BURST=1, both valid continuously, req0 data 4'h1, req1 data 4'h2, out_ready=1 -> grants 0,1,0,1 on consecutive cycles; out_code alternates 7'h07 / 7'h19 (out_pall 1 / 1).
- MAX_BURST=3, both valid for 8 transfers -> out_src sequence 0,0,0,1,1,1,0,0.
- Transfer 4'hF, then out_ready=0 for 5 cycles while both requesters are valid -> out_code stays 7'h7F, out_valid=1, both readys 0; when out_ready=1 the next grant loads in the same cycle as the pop.
- Assert rst for 1 cycle during a stall with out_valid=1 -> next cycle out_valid=0, out_code=0; first contended grant after release goes to requester 0.
- Single requester req1 streaming 4'h0 with out_ready toggling 1,0,1,0 -> no codeword lost or duplicated; each accepted nibble yields exactly one out_code=7'h00 with out_src=1.

Source files
------------

// File: rtl/hamming_enc_arbiter.sv
// Round-robin arbiter sharing one Hamming(7,4) encoder between two nibble requesters,
// with a burst limit and a single registered output slot. Optional macro HAMMING_ARB_SECDED_EN adds out_pall.
module hamming_enc_arbiter #(
    parameter int unsigned MAX_BURST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [3:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_data,
    output logic       req1_ready,
    output logic       out_valid,
    output logic [6:0] out_code,
    output logic       out_src,
    input  logic       out_ready
`ifdef HAMMING_ARB_SECDED_EN
    ,
    output logic       out_pall
`endif
);

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CODE_W = 7;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    // Hamming(7,4): parity bits at positions 1, 2, 4 (bits 0, 1, 3).
    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        return c;
    endfunction

    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              src_q, src_d;
`ifdef HAMMING_ARB_SECDED_EN
    logic              pall_q, pall_d;
`endif

    logic              slot_free_c;
    logic              sel_c;
    logic              xfer_c;
    logic [DATA_W-1:0] xfer_data_c;
    logic [CODE_W-1:0] xfer_code_c;

    // Requester selection: burst limit only matters under contention.
    always_comb begin
        slot_free_c = !out_valid_q || out_ready;
        sel_c       = 1'b0;
        if (req0_valid && req1_valid) begin
            sel_c = (cnt_q < CNT_MAX) ? owner_q : !owner_q;
        end else if (req1_valid) begin
            sel_c = 1'b1;
        end
    end

    assign req0_ready = !rst && slot_free_c && req0_valid && !sel_c;
    assign req1_ready = !rst && slot_free_c && req1_valid &&  sel_c;

    always_comb begin
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        code_d      = code_q;
        src_d       = src_q;
        xfer_c      = req0_ready || req1_ready;
        xfer_data_c = req1_ready ? req1_data : req0_data;
        xfer_code_c = encode(xfer_data_c);
`ifdef HAMMING_ARB_SECDED_EN
        pall_d      = pall_q;
`endif
        if (xfer_c) begin
            out_valid_d = 1'b1;
            code_d      = xfer_code_c;
            src_d       = req1_ready;
`ifdef HAMMING_ARB_SECDED_EN
            pall_d      = ^xfer_code_c;
`endif
            if (req1_ready == owner_q) begin
                cnt_d = (cnt_q < CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
            end else begin
                owner_d = req1_ready;
                cnt_d   = CNT_W'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            code_q      <= '0;
            src_q       <= 1'b0;
`ifdef HAMMING_ARB_SECDED_EN
            pall_q      <= 1'b0;
`endif
        end else begin
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            code_q      <= code_d;
            src_q       <= src_d;
`ifdef HAMMING_ARB_SECDED_EN
            pall_q      <= pall_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_code  = code_q;
    assign out_src   = src_q;
`ifdef HAMMING_ARB_SECDED_EN
    assign out_pall  = pall_q;
`endif

endmodule
